// File: rtl/ppd_pkg.sv
// ppd_pkg -- shared definitions for the polyphase-decimator commutator.
//   state_t   : commutator FSM states (S_FILL while priming, S_RUN once primed)
//   ppd_width : counter width helper, never narrower than one bit
package ppd_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic int unsigned ppd_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ppd_phase_counter.sv
// ppd_phase_counter -- enabled modulo counter, reset to 0, with wrap strobe.
// Ports:
//   i_clk      rising-edge clock
//   i_rst_an   asynchronous active-low reset
//   i_ena      count enable
//   i_clr      synchronous clear, overrides i_ena
//   o_count    current count, 0..gp_modulus-1
//   o_wrap     combinational: high on an enabled cycle at the last count
module ppd_phase_counter
    import ppd_pkg::*;
#(
    parameter int unsigned gp_modulus = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_an,
    input  logic                                i_ena,
    input  logic                                i_clr,
    output logic [ppd_width(gp_modulus)-1:0]    o_count,
    output logic                                o_wrap
);

    localparam int unsigned CW = ppd_width(gp_modulus);
    localparam logic [CW-1:0] LAST = CW'(gp_modulus - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            count_q <= '0;
        end else if (i_clr) begin
            count_q <= '0;
        end else if (i_ena) begin
            if (count_q == LAST) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign o_count = count_q;
    assign o_wrap  = i_ena && !i_clr && (count_q == LAST);

endmodule

// File: rtl/ppd_commutator_ctrl.sv
// ppd_commutator_ctrl -- input commutator control for a polyphase decimator.
// Steers each input sample (i_ena) to one branch shift register in rotating
// order, tracks how many full frames have been loaded, and flags a decimated
// output frame every gp_nr_phases samples once all branches are primed.
// Ports:
//   i_clk         rising-edge clock
//   i_rst_an      asynchronous active-low reset
//   i_ena         input-sample strobe
//   i_clr         synchronous clear (only with PPD_COMMUTATOR_CTRL_SYNC_CLR_EN)
//   o_branch_ena  one-hot branch write enables, zero-latency from i_ena
//   o_phase       branch index that receives the next sample
//   o_primed      registered, high while every branch holds gp_nr_taps samples
//   o_out_valid   registered one-cycle pulse per decimated output frame
// Build option: define PPD_COMMUTATOR_CTRL_SYNC_CLR_EN to add the i_clr port.
module ppd_commutator_ctrl
    import ppd_pkg::*;
#(
    parameter int unsigned gp_nr_phases = 4,
    parameter int unsigned gp_nr_taps   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_an,
    input  logic                              i_ena,
`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
    input  logic                              i_clr,
`endif
    output logic [gp_nr_phases-1:0]           o_branch_ena,
    output logic [$clog2(gp_nr_phases)-1:0]   o_phase,
    output logic                              o_primed,
    output logic                              o_out_valid
);

    localparam int unsigned FW = ppd_width(gp_nr_taps + 1);
    localparam logic [FW-1:0] FRAME_MAX  = FW'(gp_nr_taps);
    localparam logic [FW-1:0] FRAME_LAST = FW'(gp_nr_taps - 1);

    logic                             clr;
    logic                             ena_eff;
    logic                             wrap;
    logic [$clog2(gp_nr_phases)-1:0]  phase;
    logic [FW-1:0]                    frame_q;
    state_t                           state_q;
    state_t                           state_next;
    logic                             valid_next;

`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
    assign clr = i_clr;
`else
    assign clr = 1'b0;
`endif

    // Clear wins over a simultaneous sample strobe.
    assign ena_eff = i_ena && !clr;

    ppd_phase_counter #(
        .gp_modulus (gp_nr_phases)
    ) u_phase_counter (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_clr    (clr),
        .o_count  (phase),
        .o_wrap   (wrap)
    );

    assign o_phase = phase;

    always_comb begin
        o_branch_ena = '0;
        if (ena_eff) begin
            o_branch_ena[phase] = 1'b1;
        end
    end

    // Frame counter saturates at gp_nr_taps; only its value in S_FILL matters.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            frame_q <= '0;
        end else if (clr) begin
            frame_q <= '0;
        end else if (wrap && (frame_q != FRAME_MAX)) begin
            frame_q <= frame_q + FW'(1);
        end
    end

    always_comb begin
        state_next = state_q;
        valid_next = 1'b0;
        if (clr) begin
            state_next = S_FILL;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (wrap && (frame_q == FRAME_LAST)) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    state_next = S_RUN;
                end
                default: begin
                    state_next = S_FILL;
                end
            endcase
            // Includes the priming wrap, since it is judged on the next state.
            valid_next = wrap && (state_next == S_RUN);
        end
    end

    // o_primed is registered from the next state so it tracks S_RUN exactly.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q     <= S_FILL;
            o_primed    <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            state_q     <= state_next;
            o_primed    <= (state_next == S_RUN);
            o_out_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_ppd_commutator_ctrl.sv
// tb_ppd_commutator_ctrl -- self-checking bench for ppd_commutator_ctrl.
// Two instances share one stimulus: dut 0 with P=4,T=3 and dut 1 with P=2,T=1.
// The reference model counts accepted samples n since the last restart:
// phase = n mod P, primed = n >= P*T, out_valid follows a sample that makes
// n a multiple of P with n >= P*T.
// Build option: PPD_COMMUTATOR_CTRL_SYNC_CLR_EN adds the i_clr scenario.
module tb_ppd_commutator_ctrl;

    localparam int PA = 4;
    localparam int TA = 3;
    localparam int PB = 2;
    localparam int TB = 1;
`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic clr;

    logic [3:0] be_a;
    logic [1:0] ph_a;
    logic       pr_a;
    logic       ov_a;
    logic [1:0] be_b;
    logic [0:0] ph_b;
    logic       pr_b;
    logic       ov_b;

    always #5 clk = ~clk;

    ppd_commutator_ctrl #(
        .gp_nr_phases (PA),
        .gp_nr_taps   (TA)
    ) u_dut_a (
        .i_clk        (clk),
        .i_rst_an     (rst_n),
        .i_ena        (ena),
`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
        .i_clr        (clr),
`endif
        .o_branch_ena (be_a),
        .o_phase      (ph_a),
        .o_primed     (pr_a),
        .o_out_valid  (ov_a)
    );

    ppd_commutator_ctrl #(
        .gp_nr_phases (PB),
        .gp_nr_taps   (TB)
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst_an     (rst_n),
        .i_ena        (ena),
`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
        .i_clr        (clr),
`endif
        .o_branch_ena (be_b),
        .o_phase      (ph_b),
        .o_primed     (pr_b),
        .o_out_valid  (ov_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state and per-cycle expectations / observations
    int       pp [2] = '{PA, PB};
    int       tt [2] = '{TA, TB};
    int       acc[2];
    logic [3:0] exp_be[2];
    logic [3:0] obs_be[2];
    int       exp_ph[2];
    int       obs_ph[2];
    logic     exp_pr[2];
    logic     obs_pr[2];
    logic     exp_ov[2];
    logic     obs_ov[2];

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit e, input bit c);
        bit c_eff;
        c_eff = c && HAS_CLR;
        ena = e;
        clr = c;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_ph[d] = acc[d] % pp[d];
            exp_be[d] = (e && !c_eff) ? (4'b0001 << exp_ph[d]) : 4'b0000;
        end
        obs_be[0] = be_a;
        obs_be[1] = {2'b00, be_b};
        obs_ph[0] = int'(ph_a);
        obs_ph[1] = int'(ph_b);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_ov[d] = 1'b0;
            if (c_eff) begin
                acc[d] = 0;
            end else if (e) begin
                acc[d]++;
                exp_ov[d] = (acc[d] % pp[d] == 0) && (acc[d] >= pp[d] * tt[d]);
            end
            exp_pr[d] = (acc[d] >= pp[d] * tt[d]);
        end
        #1;
        obs_pr[0] = pr_a;
        obs_pr[1] = pr_b;
        obs_ov[0] = ov_a;
        obs_ov[1] = ov_b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        clr   = 1'b0;
        #3;
        acc[0] = 0;
        acc[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        clr   = 1'b0;
        acc[0] = 0;
        acc[1] = 0;
        #2;
        n_checks += 4;
        if (be_a !== 4'b0000) begin n_fail++; $display("FAIL reset_be_a: got %b expected 0000", be_a); end
        if (ph_a !== 2'd0)    begin n_fail++; $display("FAIL reset_ph_a: got %0d expected 0", ph_a); end
        if (pr_a !== 1'b0)    begin n_fail++; $display("FAIL reset_pr_a: got %b expected 0", pr_a); end
        if (ov_a !== 1'b0)    begin n_fail++; $display("FAIL reset_ov_a: got %b expected 0", ov_a); end
        ena = 1'b1;
        #1;
        n_checks += 3;
        if (be_a !== 4'b0001) begin n_fail++; $display("FAIL reset_be_ena_a: got %b expected 0001", be_a); end
        if (be_b !== 2'b01)   begin n_fail++; $display("FAIL reset_be_ena_b: got %b expected 01", be_b); end
        if (pr_b !== 1'b0)    begin n_fail++; $display("FAIL reset_pr_b: got %b expected 0", pr_b); end
        ena = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        int first;
        int pulses;
        do_reset();
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            cycle(1'b1, 1'b0);
            for (int d = 0; d < 2; d++) begin
                n_checks += 4;
                if (obs_be[d] !== exp_be[d]) begin n_fail++; $display("FAIL cont_be dut%0d i=%0d: got %b expected %b", d, i, obs_be[d], exp_be[d]); end
                if (obs_ph[d] !== exp_ph[d]) begin n_fail++; $display("FAIL cont_ph dut%0d i=%0d: got %0d expected %0d", d, i, obs_ph[d], exp_ph[d]); end
                if (obs_pr[d] !== exp_pr[d]) begin n_fail++; $display("FAIL cont_pr dut%0d i=%0d: got %b expected %b", d, i, obs_pr[d], exp_pr[d]); end
                if (obs_ov[d] !== exp_ov[d]) begin n_fail++; $display("FAIL cont_ov dut%0d i=%0d: got %b expected %b", d, i, obs_ov[d], exp_ov[d]); end
            end
            if (obs_ov[0] === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        n_checks += 2;
        if (first !== 12) begin n_fail++; $display("FAIL cont_first_valid: got sample %0d expected 12", first); end
        if (pulses !== 4) begin n_fail++; $display("FAIL cont_pulse_count: got %0d expected 4", pulses); end
    endtask

    task automatic test_sparse();
        int nacc;
        int hits[$];
        do_reset();
        nacc = 0;
        for (int i = 0; i < 60; i++) begin
            bit e;
            e = (i % 3 == 0);
            cycle(e, 1'b0);
            if (e) nacc++;
            for (int d = 0; d < 2; d++) begin
                n_checks += 4;
                if (obs_be[d] !== exp_be[d]) begin n_fail++; $display("FAIL sparse_be dut%0d i=%0d: got %b expected %b", d, i, obs_be[d], exp_be[d]); end
                if (obs_ph[d] !== exp_ph[d]) begin n_fail++; $display("FAIL sparse_ph dut%0d i=%0d: got %0d expected %0d", d, i, obs_ph[d], exp_ph[d]); end
                if (obs_pr[d] !== exp_pr[d]) begin n_fail++; $display("FAIL sparse_pr dut%0d i=%0d: got %b expected %b", d, i, obs_pr[d], exp_pr[d]); end
                if (obs_ov[d] !== exp_ov[d]) begin n_fail++; $display("FAIL sparse_ov dut%0d i=%0d: got %b expected %b", d, i, obs_ov[d], exp_ov[d]); end
            end
            if (obs_ov[0] === 1'b1) hits.push_back(nacc);
        end
        n_checks++;
        if (hits.size() != 3 || hits[0] != 12 || hits[1] != 16 || hits[2] != 20) begin
            n_fail++;
            $display("FAIL sparse_valid_points: got %p expected 12,16,20", hits);
        end
    endtask

    task automatic test_reset_midframe();
        int first;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0);
            n_checks += 2;
            if (obs_be[0] !== exp_be[0]) begin n_fail++; $display("FAIL mid_pre_be i=%0d: got %b expected %b", i, obs_be[0], exp_be[0]); end
            if (obs_pr[0] !== exp_pr[0]) begin n_fail++; $display("FAIL mid_pre_pr i=%0d: got %b expected %b", i, obs_pr[0], exp_pr[0]); end
        end
        // ena still high from the last sample; reset lands between edges
        #3;
        rst_n = 1'b0;
        acc[0] = 0;
        acc[1] = 0;
        #1;
        n_checks += 6;
        if (ph_a !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_ph_a: got %0d expected 0", ph_a); end
        if (be_a !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_be_a: got %b expected 0001", be_a); end
        if (pr_a !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_pr_a: got %b expected 0", pr_a); end
        if (ov_a !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_ov_a: got %b expected 0", ov_a); end
        if (pr_b !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_pr_b: got %b expected 0", pr_b); end
        if (ph_b !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_ph_b: got %0d expected 0", ph_b); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle(1'b1, 1'b0);
            for (int d = 0; d < 2; d++) begin
                n_checks += 3;
                if (obs_ph[d] !== exp_ph[d]) begin n_fail++; $display("FAIL mid_ph dut%0d i=%0d: got %0d expected %0d", d, i, obs_ph[d], exp_ph[d]); end
                if (obs_pr[d] !== exp_pr[d]) begin n_fail++; $display("FAIL mid_pr dut%0d i=%0d: got %b expected %b", d, i, obs_pr[d], exp_pr[d]); end
                if (obs_ov[d] !== exp_ov[d]) begin n_fail++; $display("FAIL mid_ov dut%0d i=%0d: got %b expected %b", d, i, obs_ov[d], exp_ov[d]); end
            end
            if (obs_ov[0] === 1'b1 && first == 0) first = i;
        end
        n_checks++;
        if (first !== 12) begin n_fail++; $display("FAIL mid_first_valid: got sample %0d expected 12", first); end
    endtask

    task automatic test_two_phase();
        int hits[$];
        int first_pr;
        do_reset();
        first_pr = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0);
            n_checks += 2;
            if (obs_be[1] !== exp_be[1]) begin n_fail++; $display("FAIL p2_be i=%0d: got %b expected %b", i, obs_be[1], exp_be[1]); end
            if (obs_ov[1] !== exp_ov[1]) begin n_fail++; $display("FAIL p2_ov i=%0d: got %b expected %b", i, obs_ov[1], exp_ov[1]); end
            if (obs_pr[1] === 1'b1 && first_pr == 0) first_pr = i;
            if (obs_ov[1] === 1'b1) hits.push_back(i);
        end
        n_checks += 2;
        if (first_pr !== 2) begin n_fail++; $display("FAIL p2_first_primed: got sample %0d expected 2", first_pr); end
        if (hits.size() != 4 || hits[0] != 2 || hits[1] != 4 || hits[2] != 6 || hits[3] != 8) begin
            n_fail++;
            $display("FAIL p2_valid_points: got %p expected 2,4,6,8", hits);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit e;
            bit c;
            e = ($urandom_range(0, 3) != 0);
            c = HAS_CLR && ($urandom_range(0, 39) == 0);
            cycle(e, c);
            for (int d = 0; d < 2; d++) begin
                n_checks += 4;
                if (obs_be[d] !== exp_be[d]) begin n_fail++; $display("FAIL rand_be dut%0d i=%0d: got %b expected %b", d, i, obs_be[d], exp_be[d]); end
                if (obs_ph[d] !== exp_ph[d]) begin n_fail++; $display("FAIL rand_ph dut%0d i=%0d: got %0d expected %0d", d, i, obs_ph[d], exp_ph[d]); end
                if (obs_pr[d] !== exp_pr[d]) begin n_fail++; $display("FAIL rand_pr dut%0d i=%0d: got %b expected %b", d, i, obs_pr[d], exp_pr[d]); end
                if (obs_ov[d] !== exp_ov[d]) begin n_fail++; $display("FAIL rand_ov dut%0d i=%0d: got %b expected %b", d, i, obs_ov[d], exp_ov[d]); end
            end
        end
    endtask

`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
    task automatic test_clear();
        do_reset();
        // 14 samples: dut 0 is in S_RUN with phase 2
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0);
        n_checks += 2;
        if (pr_a !== 1'b1) begin n_fail++; $display("FAIL clr_pre_primed: got %b expected 1", pr_a); end
        if (ph_a !== 2'd2) begin n_fail++; $display("FAIL clr_pre_phase: got %0d expected 2", ph_a); end
        cycle(1'b1, 1'b1);
        n_checks += 3;
        if (obs_be[0] !== 4'b0000) begin n_fail++; $display("FAIL clr_be: got %b expected 0000", obs_be[0]); end
        if (obs_pr[0] !== 1'b0)    begin n_fail++; $display("FAIL clr_primed: got %b expected 0", obs_pr[0]); end
        if (obs_ov[0] !== 1'b0)    begin n_fail++; $display("FAIL clr_ov: got %b expected 0", obs_ov[0]); end
        cycle(1'b1, 1'b0);
        n_checks += 2;
        if (obs_ph[0] !== 0)       begin n_fail++; $display("FAIL clr_next_phase: got %0d expected 0", obs_ph[0]); end
        if (obs_be[0] !== 4'b0001) begin n_fail++; $display("FAIL clr_next_be: got %b expected 0001", obs_be[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_sparse();
        test_reset_midframe();
        test_two_phase();
`ifdef PPD_COMMUTATOR_CTRL_SYNC_CLR_EN
        test_clear();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
